dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 118 +++++++++++
 tb/tb_dmem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU port A and DMA port B share one
// asynchronous-read memory, with round-robin arbitration and a bounded B burst lock.
module dmem_arbiter #(
    parameter int MAX_LOCK  = 4,
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_ready,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    output logic        a_err,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic        b_lock,
    output logic        b_ready,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        b_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {RR = 1'b0, LOCK_B = 1'b1} state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_LOCK);

    state_t     state;
    logic       last_b;
    logic [3:0] lock_cnt;
    logic       gnt_a, gnt_b;
    logic       a_in_range, b_in_range;

    assign a_in_range = ({2'b00, a_addr[31:2]} < 32'(MEM_WORDS));
    assign b_in_range = ({2'b00, b_addr[31:2]} < 32'(MEM_WORDS));

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (state == RR) begin
            if (a_req && b_req) begin
                gnt_a = last_b;
                gnt_b = !last_b;
            end else begin
                gnt_a = a_req;
                gnt_b = b_req;
            end
        end else begin
            // B keeps the memory until its burst budget is spent and A is waiting
            if (b_req && (lock_cnt != MAX_CNT || !a_req)) gnt_b = 1'b1;
            else                                          gnt_a = a_req;
        end
    end

    // Gating with rst_n discards any transfer whose edge falls inside reset
    assign a_ready = gnt_a & rst_n;
    assign b_ready = gnt_b & rst_n;

    assign mem_addr  = a_ready ? a_addr  : (b_ready ? b_addr  : 32'h0);
    assign mem_wdata = a_ready ? a_wdata : (b_ready ? b_wdata : 32'h0);
    assign mem_we    = (a_ready & a_we & a_in_range) | (b_ready & b_we & b_in_range);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RR;
            last_b   <= 1'b1;
            lock_cnt <= 4'd0;
        end else begin
            if (a_ready)      last_b <= 1'b0;
            else if (b_ready) last_b <= 1'b1;

            if (state == RR) begin
                if (b_ready && b_lock) begin
                    state    <= LOCK_B;
                    lock_cnt <= 4'd1;
                end
            end else begin
                if (!b_lock || (lock_cnt == MAX_CNT && a_req)) begin
                    state    <= RR;
                    lock_cnt <= 4'd0;
                end else if (b_ready && lock_cnt != MAX_CNT) begin
                    lock_cnt <= lock_cnt + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid <= 1'b0;
            a_rdata  <= 32'h0;
            a_err    <= 1'b0;
            b_rvalid <= 1'b0;
            b_rdata  <= 32'h0;
            b_err    <= 1'b0;
        end else begin
            a_rvalid <= a_ready;
            b_rvalid <= b_ready;
            if (a_ready) begin
                a_rdata <= (!a_we && a_in_range) ? mem_rdata : 32'h0;
                a_err   <= !a_in_range;
            end
            if (b_ready) begin
                b_rdata <= (!b_we && b_in_range) ? mem_rdata : 32'h0;
                b_err   <= !b_in_range;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_dmem_arbiter;

    localparam int MAX_LOCK = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0;
    logic        a_ready, a_rvalid, a_err;
    logic [31:0] a_rdata;
    logic        b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
    logic [31:0] b_addr = '0, b_wdata = '0;
    logic        b_ready, b_rvalid, b_err;
    logic [31:0] b_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    dmem_arbiter #(.MAX_LOCK(MAX_LOCK), .MEM_WORDS(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
        .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory the arbiter drives
    logic [31:0] dmem [64];
    assign mem_rdata = dmem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;

    // Behavioural model
    logic [31:0] ref_mem [64];
    bit          m_lock;
    int          m_cnt;
    bit          m_last_b;
    bit          ga, gb;
    logic [32:0] a_exp_q[$], b_exp_q[$];
    logic [32:0] a_hold, b_hold;
    logic        last_a_rdy, last_b_rdy, last_mem_we;

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit in_range(input logic [31:0] ad);
        return ad < 32'h100;
    endfunction

    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 7) == 0) return $urandom | 32'h0000_0100;
        return 32'($urandom_range(0, 63));
    endfunction

    // Who owns the memory this cycle according to the arbitration rules
    task automatic model_grant();
        ga = 0;
        gb = 0;
        if (!m_lock) begin
            if (a_req && b_req) begin
                ga = m_last_b;
                gb = !m_last_b;
            end else begin
                ga = a_req;
                gb = b_req;
            end
        end else if (b_req && (m_cnt < MAX_LOCK || !a_req)) gb = 1;
        else ga = a_req;
    endtask

    task automatic model_edge();
        logic [31:0] ad;
        logic        we;
        logic [32:0] resp;
        if (ga || gb) begin
            ad = ga ? a_addr : b_addr;
            we = ga ? a_we : b_we;
            if (!in_range(ad))  resp = {1'b1, 32'h0};
            else if (we)        resp = {1'b0, 32'h0};
            else                resp = {1'b0, ref_mem[ad >> 2]};
            if (we && in_range(ad)) ref_mem[ad >> 2] = ga ? a_wdata : b_wdata;
            if (ga) a_exp_q.push_back(resp);
            else    b_exp_q.push_back(resp);
            m_last_b = gb;
        end
        if (!m_lock) begin
            if (gb && b_lock) begin
                m_lock = 1;
                m_cnt  = 1;
            end
        end else if (!b_lock || (m_cnt == MAX_LOCK && a_req)) begin
            m_lock = 0;
            m_cnt  = 0;
        end else if (gb && m_cnt < MAX_LOCK) begin
            m_cnt++;
        end
    endtask

    task automatic check_resp();
        logic [32:0] e;
        if (a_exp_q.size() != 0) begin
            e = a_exp_q.pop_front();
            chk_b("a_rvalid", a_rvalid, 1'b1);
            a_hold = e;
        end else chk_b("a_rvalid", a_rvalid, 1'b0);
        chk("a_rdata", a_rdata, a_hold[31:0]);
        chk_b("a_err", a_err, a_hold[32]);
        if (b_exp_q.size() != 0) begin
            e = b_exp_q.pop_front();
            chk_b("b_rvalid", b_rvalid, 1'b1);
            b_hold = e;
        end else chk_b("b_rvalid", b_rvalid, 1'b0);
        chk("b_rdata", b_rdata, b_hold[31:0]);
        chk_b("b_err", b_err, b_hold[32]);
    endtask

    // One cycle: called at a negedge with inputs already driven, returns at the next negedge
    task automatic step();
        logic [31:0] ead;
        #1;
        model_grant();
        ead = ga ? a_addr : (gb ? b_addr : 32'h0);
        chk_b("a_ready", a_ready, ga);
        chk_b("b_ready", b_ready, gb);
        chk("mem_addr", mem_addr, ead);
        chk("mem_wdata", mem_wdata, ga ? a_wdata : (gb ? b_wdata : 32'h0));
        chk_b("mem_we", mem_we, (ga && a_we && in_range(a_addr)) || (gb && b_we && in_range(b_addr)));
        last_a_rdy  = a_ready;
        last_b_rdy  = b_ready;
        last_mem_we = mem_we;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_resp();
    endtask

    // Called at a negedge; releases reset at a later negedge
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_lock = 0;
        m_cnt = 0;
        m_last_b = 1;
        a_exp_q.delete();
        b_exp_q.delete();
        a_hold = '0;
        b_hold = '0;
        chk_b("rst a_rvalid", a_rvalid, 1'b0);
        chk_b("rst b_rvalid", b_rvalid, 1'b0);
        chk("rst a_rdata", a_rdata, 32'h0);
        chk("rst b_rdata", b_rdata, 32'h0);
        chk_b("rst a_err", a_err, 1'b0);
        chk_b("rst b_err", b_err, 1'b0);
        chk_b("rst a_ready", a_ready, 1'b0);
        chk_b("rst b_ready", b_ready, 1'b0);
        chk_b("rst mem_we", mem_we, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_a(input logic r, input logic w, input logic [31:0] ad, input logic [31:0] wd);
        a_req = r; a_we = w; a_addr = ad; a_wdata = wd;
    endtask

    task automatic drive_b(input logic r, input logic w, input logic [31:0] ad, input logic [31:0] wd, input logic l);
        b_req = r; b_we = w; b_addr = ad; b_wdata = wd; b_lock = l;
    endtask

    initial begin
        bit a_pend, b_pend;
        bit exp_pat [7];
        for (int i = 0; i < 64; i++) begin
            dmem[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        @(negedge clk);
        do_reset();

        // Store then load on port A
        drive_a(1, 1, 32'h4, 32'hDEADBEEF);
        step();
        chk_b("st a_ready", last_a_rdy, 1'b1);
        chk_b("st mem_we", last_mem_we, 1'b1);
        chk_b("st ack rvalid", a_rvalid, 1'b1);
        chk("st ack rdata", a_rdata, 32'h0);
        drive_a(1, 0, 32'h4, 32'h0);
        step();
        chk_b("ld mem_we", last_mem_we, 1'b0);
        chk_b("ld rvalid", a_rvalid, 1'b1);
        chk("ld rdata", a_rdata, 32'hDEADBEEF);
        chk_b("ld err", a_err, 1'b0);

        // Out-of-range accesses on port B
        drive_a(0, 0, 0, 0);
        drive_b(1, 0, 32'h100, 32'h0, 0);
        step();
        chk_b("oor ld mem_we", last_mem_we, 1'b0);
        chk_b("oor ld err", b_err, 1'b1);
        chk("oor ld rdata", b_rdata, 32'h0);
        drive_b(1, 1, 32'h100, 32'h12345678, 0);
        step();
        chk_b("oor st mem_we", last_mem_we, 1'b0);
        chk_b("oor st err", b_err, 1'b1);
        chk("oor word0", dmem[0], 32'h0);

        // Byte offset ignored
        drive_b(1, 1, 32'h8, 32'hA5A5A5A5, 0);
        step();
        drive_b(0, 0, 0, 0, 0);
        drive_a(1, 0, 32'h9, 32'h0);
        step();
        chk("offset rdata", a_rdata, 32'hA5A5A5A5);

        // Round-robin alternation after reset
        drive_a(0, 0, 0, 0);
        do_reset();
        drive_a(1, 0, 32'h4, 0);
        drive_b(1, 0, 32'h8, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_b("rr a_grant", last_a_rdy, (i % 2) == 0);
            chk_b("rr b_grant", last_b_rdy, (i % 2) == 1);
            chk_b("rr a_rvalid", a_rvalid, (i % 2) == 0);
            chk_b("rr b_rvalid", b_rvalid, (i % 2) == 1);
        end

        // Lock burst: A, then four B, then A, then B re-enters lock
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0);
        do_reset();
        exp_pat = '{0, 1, 1, 1, 1, 0, 1};
        drive_a(1, 0, 32'h4, 0);
        drive_b(1, 0, 32'h8, 0, 1);
        for (int i = 0; i < 7; i++) begin
            step();
            chk_b("lock b_grant", last_b_rdy, exp_pat[i]);
        end

        // Reset in the middle of a lock with a response in flight
        drive_a(0, 0, 0, 0);
        do_reset();
        drive_b(1, 0, 32'h0, 0, 1);
        step();
        chk_b("pre-rst b_rvalid", b_rvalid, 1'b1);
        drive_a(1, 1, 32'hC, 32'hCAFEF00D);
        do_reset();
        chk("rst no write", dmem[3], ref_mem[3]);
        drive_a(1, 0, 32'h4, 0);
        drive_b(1, 0, 32'h8, 0, 1);
        step();
        chk_b("post-rst a first", last_a_rdy, 1'b1);

        // Randomized traffic
        a_pend = 0;
        b_pend = 0;
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            if (!a_pend) begin
                if ($urandom_range(0, 9) < 6) begin
                    drive_a(1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
                    a_pend = 1;
                end else a_req = 0;
            end
            if (!b_pend) begin
                if ($urandom_range(0, 9) < 6) begin
                    drive_b(1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom, b_lock);
                    b_pend = 1;
                end else b_req = 0;
            end
            if ($urandom_range(0, 7) == 0) b_lock = ~b_lock;
            step();
            if (last_a_rdy) a_pend = 0;
            if (last_b_rdy) b_pend = 0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
